retire_trace_buf: RTL
=====================

# retire_trace_buf

Synthesizable retire-event recorder that sits directly downstream of the processor's retire-visible signals (PC, register-file write port, data-memory port, halt). Each cycle it classifies the retiring activity into one trace event, numbers it, and buffers it in a FIFO that a consumer drains over a valid/ready handshake. It also maintains cycle and instruction counters and freezes on halt. Software-visible tracing no longer depends on simulation-only `$fdisplay`.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CNT_W`, 32: width of the counters and of the event number.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  16  PC of the retiring instruction.
- `reg_write`  in  1  register file written this cycle.
- `write_reg`  in  3  destination register.
- `write_data`  in  16  register write data.
- `mem_read`  in  1  data memory read this cycle.
- `mem_write`  in  1  data memory write this cycle.
- `mem_addr`  in  16  data memory address.
- `mem_data`  in  16  data memory write data.
- `halt`  in  1  halt has reached memory/writeback.
- `out_valid`  out  1  head event available.
- `out_ready`  in  1  consumer accepts the head event.
- `out_type`  out  3  event type.
- `out_inum`  out  CNT_W  event number.
- `out_pc`, `out_reg`, `out_wdata`, `out_addr`, `out_mdata`  out  16/3/16/16/16  captured fields.
- `cycle_count`  out  CNT_W  cycles since reset while not halted.
- `inst_count`  out  CNT_W  events generated.
- `halted`  out  1  halt event generated; capture stopped.
- `overflow`  out  1  sticky: at least one event dropped.
- `drop_count`  out  CNT_W  number of events dropped.

## Operation
- Capture is enabled when `halted`=0. In that case exactly one event is generated every cycle.
- Classification uses the first match, evaluated in this order:
  - `reg_write & mem_write` → STU (3).
  - `reg_write & mem_read` → LD (2).
  - `reg_write` → REG (1).
  - `halt` → HALT (5).
  - `mem_write` → ST (4).
  - otherwise → NOP (0), which also covers branches.
- Captured fields:
  - `out_inum` = `inst_count` before the increment.
  - Fields that do not apply to the event type are stored as 0: reg/wdata for ST/NOP/HALT; addr for REG/NOP/HALT; mdata for all types except ST/STU.
- `inst_count` and `cycle_count` each increment by 1 per enabled cycle. Both wrap modulo 2^CNT_W.
- A HALT event sets `halted` on the next edge. From then on no events are generated and the counters freeze. Draining continues normally.
- Push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- If a push is not accepted:
  - the event is dropped;
  - `overflow` is set (sticky);
  - `drop_count` increments;
  - `inst_count` still increments, so `out_inum` gaps reveal the loss.
- A dropped HALT still sets `halted`.
- Pop occurs when `out_valid & out_ready`.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.

## Timing
- All outputs are 0 after reset: `out_valid`=0, all out fields, counters, `halted`, `overflow`, `drop_count`.
- Latency: an event presented in cycle N appears at the head with `out_valid`=1 in cycle N+1 when the FIFO is empty. No combinational path from the inputs to the outputs.
- Out fields are stable while `out_valid & ~out_ready`.
- Reset mid-operation flushes the FIFO and clears all state immediately. The first event after reset deassertion has inum 0.

## Structure
- Package `trace_pkg`:
  - event-type constants (NOP=0, REG=1, LD=2, STU=3, ST=4, HALT=5);
  - event record width, 102 bits (3+32+16+3+16+16+16 at CNT_W=32);
  - field offsets.
- Sub-module `trace_fifo`: generic width/depth synchronous FIFO with push/pop/full/empty. The top level holds classification, counters and halt logic.

## Test plan
- Idle for 3 cycles with `out_ready`=1, all inputs 0 → three NOP events, inum 0,1,2, each with the correct `pc`; `cycle_count`=3.
- Cycle with `reg_write`=1, `write_reg`=5, `write_data`=0x1234, `mem_write`=1, `mem_addr`=0x0040, `mem_data`=0xBEEF → one STU event with all five fields as given.
- `out_ready`=0 for 10 cycles with DEPTH=8 → 8 events buffered, `overflow`=1, `drop_count`=2. Then set `out_ready`=1 → inum 0..7 drained in order.
- Full FIFO with simultaneous push and pop → no drop and occupancy stays 8.
- `halt`=1 at inum 4 → HALT event generated, `halted`=1 on the next edge, counters frozen at 5, no further pushes, and the buffer drains fully.
- Assert `rst` asynchronously mid-stream with 3 events buffered → `out_valid` drops to 0 immediately. After release, the first event has inum 0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the retire trace buffer: event types and the
// packed event-record layout used between the classifier and the FIFO.
package trace_pkg;

   typedef enum logic [2:0] {
      EV_NOP  = 3'd0,
      EV_REG  = 3'd1,
      EV_LD   = 3'd2,
      EV_STU  = 3'd3,
      EV_ST   = 3'd4,
      EV_HALT = 3'd5
   } ev_type_e;

   // Record layout, LSB first: mdata, addr, wdata, reg, pc, inum, type.
   localparam int MDATA_LSB = 0;
   localparam int ADDR_LSB  = 16;
   localparam int WDATA_LSB = 32;
   localparam int REG_LSB   = 48;
   localparam int PC_LSB    = 51;
   localparam int INUM_LSB  = 67;

   localparam int DEF_CNT_W = 32;

   // Position of the type field, which sits above the counter-wide inum.
   function automatic int type_lsb(input int cnt_w);
      return INUM_LSB + cnt_w;
   endfunction

   function automatic int rec_w(input int cnt_w);
      return INUM_LSB + cnt_w + 3;
   endfunction

   // 102 bits for the default counter width.
   localparam int REC_W = rec_w(DEF_CNT_W);

endpackage

// File: rtl/retire_trace_buf_if.sv
// Retire-side inputs, trace stream and status of the retire trace buffer.
// The master side is the processor/consumer, the slave side is the buffer.
interface retire_trace_buf_if #(
   parameter int CNT_W = 32
);
   logic [15:0]      pc;
   logic             reg_write;
   logic [2:0]       write_reg;
   logic [15:0]      write_data;
   logic             mem_read;
   logic             mem_write;
   logic [15:0]      mem_addr;
   logic [15:0]      mem_data;
   logic             halt;

   logic             out_valid;
   logic             out_ready;
   logic [2:0]       out_type;
   logic [CNT_W-1:0] out_inum;
   logic [15:0]      out_pc;
   logic [2:0]       out_reg;
   logic [15:0]      out_wdata;
   logic [15:0]      out_addr;
   logic [15:0]      out_mdata;

   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] inst_count;
   logic             halted;
   logic             overflow;
   logic [CNT_W-1:0] drop_count;

   modport master (
      output pc, reg_write, write_reg, write_data, mem_read, mem_write,
             mem_addr, mem_data, halt, out_ready,
      input  out_valid, out_type, out_inum, out_pc, out_reg, out_wdata,
             out_addr, out_mdata, cycle_count, inst_count, halted,
             overflow, drop_count
   );

   modport slave (
      input  pc, reg_write, write_reg, write_data, mem_read, mem_write,
             mem_addr, mem_data, halt, out_ready,
      output out_valid, out_type, out_inum, out_pc, out_reg, out_wdata,
             out_addr, out_mdata, cycle_count, inst_count, halted,
             overflow, drop_count
   );

endinterface

// File: rtl/trace_fifo.sv
// Generic synchronous FIFO. Pointers carry one extra bit so that a full
// FIFO (same slot, different lap) is distinguishable from an empty one.
module trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Head is forced to zero when empty so outputs are clean after reset.
   assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer advance on accepted push/pop.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage write.
   // NOTE: the array has no reset; validity is tracked by the pointers,
   // which keeps it mappable to plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/retire_trace_buf.sv
// Retire-event recorder: classifies each enabled cycle into one trace
// event, numbers it, and queues it for a valid/ready consumer. Keeps cycle,
// event and drop counters and stops capturing after a HALT event.
module retire_trace_buf
   import trace_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 32
) (
   input logic               clk,
   input logic               rst,
   retire_trace_buf_if.slave bus
);

   localparam int W      = rec_w(CNT_W);
   localparam int TYPE_L = type_lsb(CNT_W);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   ev_type_e         ev_type;
   logic [2:0]       f_reg;
   logic [15:0]      f_wdata;
   logic [15:0]      f_addr;
   logic [15:0]      f_mdata;
   logic [W-1:0]     rec_in;
   logic [W-1:0]     rec_out;

   logic [CNT_W-1:0] cycle_q;
   logic [CNT_W-1:0] inst_q;
   logic [CNT_W-1:0] drop_q;
   logic             halted_q;
   logic             overflow_q;

   logic             full;
   logic             empty;
   logic             capture;
   logic             pop;
   logic             push_ok;
   logic             drop;

   // Classify the retiring activity (first match wins) and zero the
   // fields that do not belong to the chosen event type.
   // NOTE: every output gets a default first so no path infers a latch.
   always_comb begin
      ev_type = EV_NOP;
      f_reg   = '0;
      f_wdata = '0;
      f_addr  = '0;
      f_mdata = '0;
      if (bus.reg_write & bus.mem_write) begin
         ev_type = EV_STU;
         f_reg   = bus.write_reg;
         f_wdata = bus.write_data;
         f_addr  = bus.mem_addr;
         f_mdata = bus.mem_data;
      end else if (bus.reg_write & bus.mem_read) begin
         ev_type = EV_LD;
         f_reg   = bus.write_reg;
         f_wdata = bus.write_data;
         f_addr  = bus.mem_addr;
      end else if (bus.reg_write) begin
         ev_type = EV_REG;
         f_reg   = bus.write_reg;
         f_wdata = bus.write_data;
      end else if (bus.halt) begin
         ev_type = EV_HALT;
      end else if (bus.mem_write) begin
         ev_type = EV_ST;
         f_addr  = bus.mem_addr;
         f_mdata = bus.mem_data;
      end
   end

   assign rec_in = {ev_type, inst_q, bus.pc, f_reg, f_wdata, f_addr, f_mdata};

   assign capture = ~halted_q;
   assign pop     = ~empty & bus.out_ready;
   assign push_ok = capture & (~full | pop);
   assign drop    = capture & ~push_ok;

   trace_fifo #(
      .WIDTH (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_ok),
      .pop   (pop),
      .din   (rec_in),
      .dout  (rec_out),
      .full  (full),
      .empty (empty)
   );

   // Counters, halt latch and drop bookkeeping; all frozen once halted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_q    <= '0;
         inst_q     <= '0;
         drop_q     <= '0;
         halted_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else if (capture) begin
         cycle_q <= cycle_q + CNT_ONE;
         inst_q  <= inst_q + CNT_ONE;
         if (ev_type == EV_HALT) halted_q <= 1'b1;
         if (drop) begin
            overflow_q <= 1'b1;
            drop_q     <= drop_q + CNT_ONE;
         end
      end
   end

   assign bus.out_valid   = ~empty;
   assign bus.out_type    = rec_out[TYPE_L +: 3];
   assign bus.out_inum    = rec_out[INUM_LSB +: CNT_W];
   assign bus.out_pc      = rec_out[PC_LSB +: 16];
   assign bus.out_reg     = rec_out[REG_LSB +: 3];
   assign bus.out_wdata   = rec_out[WDATA_LSB +: 16];
   assign bus.out_addr    = rec_out[ADDR_LSB +: 16];
   assign bus.out_mdata   = rec_out[MDATA_LSB +: 16];
   assign bus.cycle_count = cycle_q;
   assign bus.inst_count  = inst_q;
   assign bus.drop_count  = drop_q;
   assign bus.halted      = halted_q;
   assign bus.overflow    = overflow_q;

endmodule
